// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: Avalon-ST video source emitting a control packet and a video packet
// per frame with a selectable test pattern; all outputs registered, readyLatency 0.
module vid_pattern_gen #(
  parameter int H_PIXELS   = 800,
  parameter int V_PIXELS   = 480,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            pattern,
  input  logic [23:0]           solid_rgb,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  startofpacket,
  output logic                  endofpacket,
  output logic                  frame_start
);
  localparam int XW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW    = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam int BAR_W = H_PIXELS / 8;

  localparam logic [15:0]           H16      = 16'(H_PIXELS);
  localparam logic [15:0]           V16      = 16'(V_PIXELS);
  localparam logic [XW-1:0]         X_LAST   = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(V_PIXELS - 1);
  localparam logic [XW-1:0]         BAR_LAST = XW'(BAR_W - 1);
  localparam logic [DATA_WIDTH-1:0] CTL_WORD = DATA_WIDTH'(32'h0000000F);

  if ((H_PIXELS % 8) != 0 || H_PIXELS < 8 || H_PIXELS > 65535) begin : g_bad_h
    $error("vid_pattern_gen: H_PIXELS must be a multiple of 8 in 8..65535");
  end
  if (V_PIXELS < 1 || V_PIXELS > 65535) begin : g_bad_v
    $error("vid_pattern_gen: V_PIXELS must be in 1..65535");
  end
  if (DATA_WIDTH < 32) begin : g_bad_w
    $error("vid_pattern_gen: DATA_WIDTH must be at least 32");
  end

  typedef enum logic [2:0] {
    IDLE,
    CTL_HDR,
    CTL_DATA,
    VID_HDR,
    VID_DATA
  } state_t;

  state_t          state, n_state;
  logic            n_valid, n_sop, n_eop, n_cy, latch, pix_load, accept;
  logic [DATA_WIDTH-1:0] n_data;
  logic [3:0]      nib, n_nib;
  logic [XW-1:0]   x, n_x, bar_cnt, n_bar_cnt;
  logic [YW-1:0]   y, n_y;
  logic [2:0]      bar, n_bar;
  logic [1:0]      frame_pat;
  logic [23:0]     frame_rgb;
  logic [1:0]      rst_sync;
  logic            rst_int_n;

  function automatic logic [3:0] ctl_nibble(input logic [3:0] idx);
    logic [3:0] n;
    n = 4'h0;
    case (idx)
      4'd0: n = H16[15:12];
      4'd1: n = H16[11:8];
      4'd2: n = H16[7:4];
      4'd3: n = H16[3:0];
      4'd4: n = V16[15:12];
      4'd5: n = V16[11:8];
      4'd6: n = V16[7:4];
      4'd7: n = V16[3:0];
      4'd8: n = 4'h3;
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // gx is the low byte of x; bit 4 of it doubles as the checkerboard column bit.
  function automatic logic [23:0] pixel_rgb(input logic [1:0] pat, input logic [23:0] rgb,
                                            input logic [7:0] gx, input logic cy,
                                            input logic [2:0] bar_idx);
    logic [23:0] c;
    c = 24'h000000;
    case (pat)
      2'd0: begin
        case (bar_idx)
          3'd0: c = 24'hFFFFFF;
          3'd1: c = 24'hFFFF00;
          3'd2: c = 24'h00FFFF;
          3'd3: c = 24'h00FF00;
          3'd4: c = 24'hFF00FF;
          3'd5: c = 24'hFF0000;
          3'd6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd1:    c = {gx, gx, gx};
      2'd2:    c = (gx[4] ^ cy) ? 24'h000000 : 24'hFFFFFF;
      default: c = rgb;
    endcase
    return c;
  endfunction

  // Reset asserts asynchronously but is released to the core only on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // The registers always describe the beat currently on the bus; this computes the next one.
  always_comb begin
    n_state   = state;
    n_valid   = valid;
    n_data    = data;
    n_sop     = startofpacket;
    n_eop     = endofpacket;
    n_nib     = nib;
    n_x       = x;
    n_y       = y;
    n_bar     = bar;
    n_bar_cnt = bar_cnt;
    latch     = 1'b0;
    pix_load  = 1'b0;
    n_cy      = 1'b0;
    accept    = valid && ready;
    case (state)
      IDLE: begin
        if (enable) begin
          n_state = CTL_HDR;
          n_valid = 1'b1;
          n_data  = CTL_WORD;
          n_sop   = 1'b1;
          n_eop   = 1'b0;
          latch   = 1'b1;
        end
      end
      CTL_HDR: begin
        if (accept) begin
          n_state = CTL_DATA;
          n_nib   = 4'd0;
          n_data  = DATA_WIDTH'(ctl_nibble(4'd0));
          n_sop   = 1'b0;
          n_eop   = 1'b0;
        end
      end
      CTL_DATA: begin
        if (accept) begin
          if (nib == 4'd8) begin
            n_state = VID_HDR;
            n_data  = '0;
            n_sop   = 1'b1;
            n_eop   = 1'b0;
          end else begin
            n_nib  = nib + 4'd1;
            n_data = DATA_WIDTH'(ctl_nibble(nib + 4'd1));
            n_eop  = (nib == 4'd7);
          end
        end
      end
      VID_HDR: begin
        if (accept) begin
          n_state   = VID_DATA;
          n_x       = '0;
          n_y       = '0;
          n_bar     = 3'd0;
          n_bar_cnt = '0;
          n_sop     = 1'b0;
          n_eop     = 1'b0;
          pix_load  = 1'b1;
        end
      end
      VID_DATA: begin
        if (accept) begin
          if (endofpacket) begin
            if (enable) begin
              n_state = CTL_HDR;
              n_data  = CTL_WORD;
              n_sop   = 1'b1;
              n_eop   = 1'b0;
              latch   = 1'b1;
            end else begin
              n_state = IDLE;
              n_valid = 1'b0;
              n_data  = '0;
              n_sop   = 1'b0;
              n_eop   = 1'b0;
            end
          end else begin
            pix_load = 1'b1;
            if (x == X_LAST) begin
              n_x       = '0;
              n_y       = y + YW'(1);
              n_bar     = 3'd0;
              n_bar_cnt = '0;
            end else begin
              n_x = x + XW'(1);
              if (bar_cnt == BAR_LAST) begin
                n_bar_cnt = '0;
                n_bar     = bar + 3'd1;
              end else begin
                n_bar_cnt = bar_cnt + XW'(1);
              end
            end
            n_eop = (n_x == X_LAST) && (n_y == Y_LAST);
          end
        end
      end
      default: begin
        n_state = IDLE;
        n_valid = 1'b0;
        n_data  = '0;
        n_sop   = 1'b0;
        n_eop   = 1'b0;
      end
    endcase
    n_cy = (5'(n_y) & 5'b10000) != 5'd0;
    if (pix_load) n_data = DATA_WIDTH'(pixel_rgb(frame_pat, frame_rgb, 8'(n_x), n_cy, n_bar));
  end

  // State, counters and the registered output beat; a stall leaves everything untouched.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= IDLE;
      valid         <= 1'b0;
      data          <= '0;
      startofpacket <= 1'b0;
      endofpacket   <= 1'b0;
      frame_start   <= 1'b0;
      nib           <= 4'd0;
      x             <= '0;
      y             <= '0;
      bar           <= 3'd0;
      bar_cnt       <= '0;
      frame_pat     <= 2'd0;
      frame_rgb     <= 24'h000000;
    end else begin
      state         <= n_state;
      valid         <= n_valid;
      data          <= n_data;
      startofpacket <= n_sop;
      endofpacket   <= n_eop;
      frame_start   <= (state == CTL_HDR) && valid && ready;
      nib           <= n_nib;
      x             <= n_x;
      y             <= n_y;
      bar           <= n_bar;
      bar_cnt       <= n_bar_cnt;
      if (latch) begin
        frame_pat <= pattern;
        frame_rgb <= solid_rgb;
      end
    end
  end
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: stimulus queues expected beats for a 16x4 and a 32x32 instance;
// a negedge monitor pops and compares each accepted beat and checks stall stability.
module tb_vid_pattern_gen;
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk, reset, enable, enable_cb, ready, rand_ready;
  logic [1:0]  pattern;
  logic [23:0] solid_rgb;
  logic        valid0, sop0, eop0, fs0;
  logic [31:0] data0;
  logic        valid1, sop1, eop1, fs1;
  logic [31:0] data1;

  beat_t q0[$];
  beat_t q1[$];
  int    acc[2];
  logic  fs_exp[2];
  logic  stalled[2];
  beat_t held[2];
  int    total, bad;

  vid_pattern_gen #(.H_PIXELS(16), .V_PIXELS(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern(pattern), .solid_rgb(solid_rgb),
    .valid(valid0), .ready(ready), .data(data0), .startofpacket(sop0),
    .endofpacket(eop0), .frame_start(fs0)
  );

  vid_pattern_gen #(.H_PIXELS(32), .V_PIXELS(32), .DATA_WIDTH(32)) dut_cb (
    .clk(clk), .reset(reset), .enable(enable_cb), .pattern(pattern), .solid_rgb(solid_rgb),
    .valid(valid1), .ready(ready), .data(data1), .startofpacket(sop1),
    .endofpacket(eop1), .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [23:0] exp_pixel(input logic [1:0] pat, input logic [23:0] rgb,
                                            input int px, input int py, input int h);
    logic [7:0] g;
    case (pat)
      2'd0: return BARS[px / (h / 8)];
      2'd1: begin
        g = 8'(px % 256);
        return {g, g, g};
      end
      2'd2: return ((((px / 16) + (py / 16)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
      default: return rgb;
    endcase
  endfunction

  task automatic push(input int inst, input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    b = {d, s, e};
    if (inst == 0) q0.push_back(b);
    else           q1.push_back(b);
  endtask

  // ctl holds the nine hand-computed control nibbles, most significant first.
  task automatic push_frame(input int inst, input int h, input int v, input logic [35:0] ctl,
                            input logic [1:0] pat, input logic [23:0] rgb);
    push(inst, 32'h0000000F, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) push(inst, 32'(ctl[35-4*i -: 4]), 1'b0, i == 8);
    push(inst, 32'h00000000, 1'b1, 1'b0);
    for (int py = 0; py < v; py++)
      for (int px = 0; px < h; px++)
        push(inst, {8'h00, exp_pixel(pat, rgb, px, py, h)}, 1'b0, (px == h - 1) && (py == v - 1));
  endtask

  task automatic monitor_port(input int inst, input logic v, input logic r, input logic [31:0] d,
                              input logic s, input logic e, input logic f);
    beat_t got, want;
    logic  hdr;
    got = {d, s, e};
    hdr = 1'b0;
    total++;
    if (f !== fs_exp[inst]) begin
      bad++;
      $display("[TB] FAIL frame_start inst%0d: got %b want %b", inst, f, fs_exp[inst]);
    end
    if (stalled[inst]) begin
      total++;
      if (v !== 1'b1 || got !== held[inst]) begin
        bad++;
        $display("[TB] FAIL stall_hold inst%0d: got v=%b data=%h sop=%b eop=%b want v=1 data=%h sop=%b eop=%b",
                 inst, v, d, s, e, held[inst].data, held[inst].sop, held[inst].eop);
      end
    end
    stalled[inst] = (v === 1'b1) && (r === 1'b0);
    held[inst]    = got;
    if (v === 1'b1 && r === 1'b1) begin
      total++;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
        bad++;
        $display("[TB] FAIL unexpected_beat inst%0d: got data=%h sop=%b eop=%b want no beat", inst, d, s, e);
      end else begin
        if (inst == 0) want = q0.pop_front();
        else           want = q1.pop_front();
        if (got !== want) begin
          bad++;
          $display("[TB] FAIL beat%0d inst%0d: got data=%h sop=%b eop=%b want data=%h sop=%b eop=%b",
                   acc[inst], inst, d, s, e, want.data, want.sop, want.eop);
        end
        hdr = want.sop && (want.data == 32'h0000000F);
      end
      acc[inst]++;
    end
    fs_exp[inst] = hdr;
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      fs_exp[0]  = 1'b0;
      fs_exp[1]  = 1'b0;
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      monitor_port(0, valid0, ready, data0, sop0, eop0, fs0);
      monitor_port(1, valid1, ready, data1, sop1, eop1, fs1);
    end
  end

  task automatic wait_acc(input int inst, input int target, input int budget);
    int n;
    n = 0;
    while (acc[inst] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (acc[inst] < target) begin
      bad++;
      $display("[TB] FAIL wait_beats inst%0d: accepted %0d want %0d", inst, acc[inst], target);
    end
  endtask

  task automatic check_output_zero(input string tag);
    total++;
    if ({valid0, data0, sop0, eop0, fs0} !== 36'h0) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b data=%h sop=%b eop=%b fs=%b want all 0",
               tag, valid0, data0, sop0, eop0, fs0);
    end
  endtask

  task automatic check_idle(input int inst, input int n);
    logic v;
    int   left;
    repeat (n) begin
      @(negedge clk);
      v = (inst == 0) ? valid0 : valid1;
      total++;
      if (v !== 1'b0) begin
        bad++;
        $display("[TB] FAIL idle_valid inst%0d: got %b want 0", inst, v);
      end
    end
    left = (inst == 0) ? q0.size() : q1.size();
    total++;
    if (left != 0) begin
      bad++;
      $display("[TB] FAIL leftover inst%0d: got %0d beats pending want 0", inst, left);
    end
  endtask

  initial begin
    int base;
    acc[0] = 0; acc[1] = 0;
    fs_exp[0] = 1'b0; fs_exp[1] = 1'b0;
    stalled[0] = 1'b0; stalled[1] = 1'b0;
    held[0] = '0; held[1] = '0;
    total = 0; bad = 0;
    reset = 1'b1; enable = 1'b0; enable_cb = 1'b0; rand_ready = 1'b0;
    pattern = 2'd0; solid_rgb = 24'h000000;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output_zero("reset_state");
    reset = 1'b1;

    // Two back-to-back colour-bar frames; enable drops during the second frame's video.
    push_frame(0, 16, 4, 36'h001000043, 2'd0, 24'h0);
    push_frame(0, 16, 4, 36'h001000043, 2'd0, 24'h0);
    base = acc[0];
    enable = 1'b1;
    wait_acc(0, base + 105, 400);
    enable = 1'b0;
    wait_acc(0, base + 150, 400);
    check_idle(0, 8);

    // Same frame under pseudo-random backpressure.
    rand_ready = 1'b1;
    push_frame(0, 16, 4, 36'h001000043, 2'd0, 24'h0);
    base = acc[0];
    enable = 1'b1;
    wait_acc(0, base + 40, 800);
    enable = 1'b0;
    wait_acc(0, base + 75, 800);
    rand_ready = 1'b0;
    check_idle(0, 5);

    // Solid frame with mid-frame pattern and colour changes, then a gradient frame.
    pattern = 2'd3;
    solid_rgb = 24'h123456;
    push_frame(0, 16, 4, 36'h001000043, 2'd3, 24'h123456);
    push_frame(0, 16, 4, 36'h001000043, 2'd1, 24'h0);
    base = acc[0];
    enable = 1'b1;
    wait_acc(0, base + 31, 400);
    pattern = 2'd1;
    solid_rgb = 24'hABCDEF;
    wait_acc(0, base + 115, 400);
    enable = 1'b0;
    wait_acc(0, base + 150, 400);
    check_idle(0, 5);

    // Reset in the middle of the video packet, then a fresh frame after release.
    pattern = 2'd0;
    push_frame(0, 16, 4, 36'h001000043, 2'd0, 24'h0);
    base = acc[0];
    enable = 1'b1;
    wait_acc(0, base + 30, 400);
    reset = 1'b0;
    #1;
    check_output_zero("reset_mid_frame");
    q0.delete();
    push_frame(0, 16, 4, 36'h001000043, 2'd0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    check_output_zero("reset_held");
    reset = 1'b1;
    base = acc[0];
    wait_acc(0, base + 40, 400);
    enable = 1'b0;
    wait_acc(0, base + 75, 400);
    check_idle(0, 5);

    // Checkerboard on the 32x32 instance.
    pattern = 2'd2;
    push_frame(1, 32, 32, 36'h002000203, 2'd2, 24'h0);
    base = acc[1];
    enable_cb = 1'b1;
    wait_acc(1, base + 100, 2000);
    enable_cb = 1'b0;
    wait_acc(1, base + 1035, 3000);
    check_idle(1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
